freq_meas_ctrl: RTL

FREQ_MEAS_CTRL -- requirements
Module: freq_meas_ctrl

---
 rtl/freq_meas_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/freq_meas_ctrl.sv
// Gated frequency-measurement sequencer with auto-ranging. The result appears 4+N cycles after START, where N is the gate length.
// A new result overwrites an unacknowledged one (LOST flags this); START is ignored while busy.
module freq_meas_ctrl #(
  parameter int unsigned GATE0_CYC = 100000000,
  parameter int unsigned GATE1_CYC = 10000000,
  parameter int unsigned GATE2_CYC = 1000000,
  parameter int unsigned LOW_THR   = 6000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        STOP,
  input  logic [15:0] CNT,
  input  logic        CNT_OVF,
  input  logic        ACK,
  output logic        GATE,
  output logic        CNT_CLR,
  output logic [15:0] FREQ,
  output logic [1:0]  RANGE,
  output logic        VALID,
  output logic        OVF,
  output logic        LOST,
  output logic        BUSY
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_GATE  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;

  localparam logic [31:0] G0_LAST = GATE0_CYC - 32'd1;
  localparam logic [31:0] G1_LAST = GATE1_CYC - 32'd1;
  localparam logic [31:0] G2_LAST = GATE2_CYC - 32'd1;
  localparam logic [15:0] LOW_THR_W = 16'(LOW_THR);

  logic [2:0]  state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [1:0]  range_q, range_d;
  logic        stop_q, stop_d;
  logic [15:0] freq_q, freq_d;
  logic [1:0]  rng_out_q, rng_out_d;
  logic        valid_q, valid_d;
  logic        ovf_q, ovf_d;
  logic        lost_q, lost_d;
  logic        cnt_sat;
  logic [31:0] gate_last;

  assign cnt_sat = CNT_OVF || (CNT == 16'hFFFF);

  always_comb begin
    case (range_q)
      2'd0:    gate_last = G0_LAST;
      2'd1:    gate_last = G1_LAST;
      default: gate_last = G2_LAST;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    range_d   = range_q;
    stop_d    = stop_q;
    freq_d    = freq_q;
    rng_out_d = rng_out_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    lost_d    = lost_q;

    if (ACK && valid_q) valid_d = 1'b0;
    if (STOP && state_q != S_IDLE) stop_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (START && !STOP) begin
          state_d = S_CLEAR;
          lost_d  = 1'b0;
          stop_d  = 1'b0;
        end
      end
      S_CLEAR: begin
        timer_d = gate_last;
        state_d = S_GATE;
      end
      S_GATE: begin
        if (timer_q == 32'd0) state_d = S_WAIT;
        else                  timer_d = timer_q - 32'd1;
      end
      S_WAIT: state_d = S_LATCH;
      S_LATCH: begin
        // Saturation below the coarsest range only widens the range; nothing is published.
        if (cnt_sat && range_q != 2'd2) begin
          range_d = range_q + 2'd1;
        end else begin
          valid_d   = 1'b1;
          if (valid_q && !ACK) lost_d = 1'b1;
          rng_out_d = range_q;
          if (cnt_sat) begin
            freq_d = 16'hFFFF;
            ovf_d  = 1'b1;
          end else begin
            freq_d = CNT;
            ovf_d  = 1'b0;
            if (CNT < LOW_THR_W && range_q != 2'd0) range_d = range_q - 2'd1;
          end
        end
        if (stop_q || STOP) begin
          state_d = S_IDLE;
          stop_d  = 1'b0;
        end else begin
          state_d = S_CLEAR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      timer_q   <= 32'd0;
      range_q   <= 2'd0;
      stop_q    <= 1'b0;
      freq_q    <= 16'd0;
      rng_out_q <= 2'd0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      range_q   <= range_d;
      stop_q    <= stop_d;
      freq_q    <= freq_d;
      rng_out_q <= rng_out_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      lost_q    <= lost_d;
    end
  end

  assign GATE    = (state_q == S_GATE);
  assign CNT_CLR = (state_q == S_CLEAR);
  assign BUSY    = (state_q != S_IDLE);
  assign FREQ    = freq_q;
  assign RANGE   = rng_out_q;
  assign VALID   = valid_q;
  assign OVF     = ovf_q;
  assign LOST    = lost_q;

endmodule
